// File: rtl/drive_pkg.sv
// drive_pkg: shared constants and state encoding for the assist-current sequencer
package drive_pkg;
    localparam logic [11:0] TORQUE_MIN = 12'h380;
    localparam int P1_W = 15;
    localparam int P2_W = 27;
    localparam int P3_W = 29;
    typedef enum logic [2:0] {IDLE, MUL_CI, MUL_T, SCALE, SAT} state_t;
endpackage

// File: rtl/drive_mult15.sv
// drive_mult15: combinational 15x15 unsigned multiplier shared across sequencer states
module drive_mult15 (
    input  logic [14:0] a,
    input  logic [14:0] b,
    output logic [29:0] p
);
    assign p = a * b;
endmodule

// File: rtl/drive_seq.sv
// drive_seq: four-cycle time-multiplexed assist-current computation with saturated output
module drive_seq
    import drive_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic        [11:0] avg_torque,
    input  logic        [4:0]  cadence_vec,
    input  logic signed [12:0] incline,
    input  logic        [1:0]  setting,
    output logic               busy,
    output logic               done,
    output logic        [11:0] target_curr
);
    state_t state;
    logic signed [9:0]  incline_sat;
    logic signed [10:0] incline_factor;
    logic [8:0]         incline_lim;
    logic [5:0]         cadence_factor;
    logic [11:0]        torque_pos;
    logic [5:0]         cf_r;
    logic [8:0]         il_r;
    logic [11:0]        tp_r;
    logic [1:0]         set_r;
    logic [P1_W-1:0]    prod1;
    logic [P2_W-1:0]    prod2;
    logic [P3_W-1:0]    prod3;
    logic [P3_W-1:0]    scaled;
    logic [14:0]        ma;
    logic [14:0]        mb;
    logic [29:0]        mp;
    logic               p_unused;
    always_comb begin
        incline_sat = (incline > 13'sd511) ? 10'sd511 :
                      (incline < -13'sd512) ? -10'sd512 : incline[9:0];
        incline_factor = {incline_sat[9], incline_sat} + 11'sd256;
        incline_lim = incline_factor[10] ? 9'd0 :
                      (incline_factor > 11'sd511) ? 9'd511 : incline_factor[8:0];
        cadence_factor = (cadence_vec[4:1] == 4'd0) ? 6'd0 : {1'b0, cadence_vec} + 6'd32;
        torque_pos = (avg_torque > TORQUE_MIN) ? avg_torque - TORQUE_MIN : 12'd0;
        ma = (state == MUL_T) ? {3'b0, tp_r} : {9'b0, cf_r};
        mb = (state == MUL_T) ? prod1 : {6'b0, il_r};
        scaled = (set_r == 2'd0) ? '0 :
                 (set_r == 2'd1) ? {2'b0, prod2} :
                 (set_r == 2'd2) ? {1'b0, prod2, 1'b0} :
                 {2'b0, prod2} + {1'b0, prod2, 1'b0};
    end
    drive_mult15 u_mult (.a(ma), .b(mb), .p(mp));
    // Product never exceeds 27 bits and the output window drops the low 14 bits of prod3.
    assign p_unused = ^{mp[29:27], prod3[13:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            target_curr <= '0;
            cf_r        <= '0;
            il_r        <= '0;
            tp_r        <= '0;
            set_r       <= '0;
            prod1       <= '0;
            prod2       <= '0;
            prod3       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cf_r  <= cadence_factor;
                    il_r  <= incline_lim;
                    tp_r  <= torque_pos;
                    set_r <= setting;
                    busy  <= 1'b1;
                    state <= MUL_CI;
                end
                MUL_CI: begin
                    prod1 <= mp[P1_W-1:0];
                    state <= MUL_T;
                end
                MUL_T: begin
                    prod2 <= mp[P2_W-1:0];
                    state <= SCALE;
                end
                SCALE: begin
                    prod3 <= scaled;
                    state <= SAT;
                end
                SAT: begin
                    target_curr <= (|prod3[28:26]) ? 12'hFFF : prod3[25:14];
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_drive_seq.sv
// tb_drive_seq: directed scenario tests for the assist-current sequencer
module tb_drive_seq;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [11:0] avg_torque = 0;
    logic [4:0]  cadence_vec = 0;
    logic [12:0] incline = 0;
    logic [1:0]  setting = 0;
    logic        busy;
    logic        done;
    logic [11:0] target_curr;
    int checks = 0;
    int failures = 0;

    drive_seq dut (
        .clk(clk), .rst(rst), .start(start), .avg_torque(avg_torque),
        .cadence_vec(cadence_vec), .incline(incline), .setting(setting),
        .busy(busy), .done(done), .target_curr(target_curr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input [11:0] t, input [4:0] c, input [12:0] i, input [1:0] s);
        avg_torque = t;
        cadence_vec = c;
        incline = i;
        setting = s;
    endtask

    task automatic run_op(input [11:0] t, input [4:0] c, input [12:0] i, input [1:0] s,
                          output int lat, output logic [11:0] res);
        set_in(t, c, i, s);
        start = 1;
        step();
        start = 0;
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        res = target_curr;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || target_curr !== 12'h000) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b target=%h expected 0 0 000", busy, done, target_curr);
        end
        rst = 0;
        step();
    endtask

    task automatic test_nominal();
        int bc;
        set_in(12'h580, 5'h10, 13'h0000, 2'd2);
        start = 1;
        step();
        start = 0;
        bc = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy === 1'b1 && done === 1'b0) bc++;
            if (k < 3) step();
        end
        checks++;
        if (bc !== 4) begin
            failures++;
            $display("FAIL nominal_busy: busy-high cycles=%0d expected 4", bc);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || target_curr !== 12'h300) begin
            failures++;
            $display("FAIL nominal_edge4: done=%b busy=%b target=%h expected 1 0 300", done, busy, target_curr);
        end
        step();
        checks++;
        if (done !== 1'b0 || target_curr !== 12'h300) begin
            failures++;
            $display("FAIL nominal_hold: done=%b target=%h expected 0 300", done, target_curr);
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [11:0] res;
        run_op(12'hFFF, 5'h1F, 13'h00FF, 2'd3, lat, res);
        checks++;
        if (lat !== 4 || res !== 12'hFFF) begin
            failures++;
            $display("FAIL sat_full: latency=%0d target=%h expected 4 fff", lat, res);
        end
        run_op(12'h480, 5'h1F, 13'h0FFF, 2'd1, lat, res);
        checks++;
        if (lat !== 4 || res !== 12'h1F7) begin
            failures++;
            $display("FAIL sat_incline_clamp: latency=%0d target=%h expected 4 1f7", lat, res);
        end
        run_op(12'h580, 5'h10, 13'h1000, 2'd2, lat, res);
        checks++;
        if (lat !== 4 || res !== 12'h000) begin
            failures++;
            $display("FAIL sat_incline_neg_clamp: latency=%0d target=%h expected 4 000", lat, res);
        end
    endtask

    task automatic test_zero_paths();
        int lat;
        logic [11:0] res;
        logic [11:0] tv[4] = '{12'h580, 12'h580, 12'h37F, 12'h580};
        logic [4:0]  cv[4] = '{5'h01, 5'h10, 5'h10, 5'h10};
        logic [12:0] iv[4] = '{13'h0000, 13'h1ED4, 13'h0000, 13'h0000};
        logic [1:0]  sv[4] = '{2'd2, 2'd2, 2'd2, 2'd0};
        for (int k = 0; k < 4; k++) begin
            run_op(12'h580, 5'h10, 13'h0000, 2'd2, lat, res);
            step();
            run_op(tv[k], cv[k], iv[k], sv[k], lat, res);
            checks++;
            if (lat !== 4 || res !== 12'h000) begin
                failures++;
                $display("FAIL zero_path_%0d: latency=%0d target=%h expected 4 000", k, lat, res);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        int lat;
        set_in(12'h580, 5'h10, 13'h0000, 2'd2);
        start = 1;
        step();
        set_in(12'hFFF, 5'h1F, 13'h00FF, 2'd3);
        dc = 0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) start = 0;
            step();
            if (done) dc++;
        end
        checks++;
        if (dc !== 1 || done !== 1'b1 || target_curr !== 12'h300) begin
            failures++;
            $display("FAIL busy_start_ignored: dones=%0d done=%b target=%h expected 1 1 300", dc, done, target_curr);
        end
        set_in(12'h580, 5'h10, 13'h0000, 2'd1);
        start = 1;
        step();
        start = 0;
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 4 || target_curr !== 12'h180) begin
            failures++;
            $display("FAIL start_on_done: latency=%0d target=%h expected 4 180", lat, target_curr);
        end
        dc = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (done) dc++;
        end
        checks++;
        if (dc !== 0) begin
            failures++;
            $display("FAIL no_queued_start: extra dones=%0d expected 0", dc);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        int lat;
        logic [11:0] res;
        set_in(12'h580, 5'h10, 13'h0000, 2'd2);
        start = 1;
        step();
        start = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || target_curr !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b target=%h expected 0 0 000", busy, done, target_curr);
        end
        dc = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (done) dc++;
        end
        checks++;
        if (dc !== 0 || target_curr !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_no_done: dones=%0d target=%h expected 0 000", dc, target_curr);
        end
        run_op(12'h580, 5'h10, 13'h0000, 2'd2, lat, res);
        checks++;
        if (lat !== 4 || res !== 12'h300) begin
            failures++;
            $display("FAIL reset_mid_restart: latency=%0d target=%h expected 4 300", lat, res);
        end
    endtask

    task automatic test_input_hold();
        int lat;
        set_in(12'h580, 5'h10, 13'h0000, 2'd2);
        start = 1;
        step();
        start = 0;
        lat = 0;
        while (!done && lat < 20) begin
            set_in(12'($urandom), 5'($urandom), 13'($urandom), 2'($urandom));
            step();
            lat++;
        end
        checks++;
        if (lat !== 4 || target_curr !== 12'h300) begin
            failures++;
            $display("FAIL input_hold: latency=%0d target=%h expected 4 300", lat, target_curr);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_zero_paths();
        test_back_to_back();
        test_reset_mid();
        test_input_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/drive_seq.md
# drive_seq

Time-multiplexed controller for the eBike assist-current computation. Captures one sample of rider torque, cadence, incline and assist setting on a `start` strobe. Sequences the assist product through a single shared multiplier over four cycles and publishes a saturated 12-bit target current with a one-cycle `done` pulse. It sits between the sensor-conditioning logic (avg_torque, cadence_vec, incline) and the motor current loop, and is the area-reduced alternative to a fully pipelined assist datapath.

## Interface
- TORQUE_MIN, 12'h380, torque offset subtracted from avg_torque before the product
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request one computation; sampled only in IDLE
- avg_torque  in  12  unsigned averaged crank torque
- cadence_vec  in  5  unsigned cadence measure
- incline  in  13  signed (two's complement) incline
- setting  in  2  assist level 0..3
- busy  out  1  high while a computation is in flight
- done  out  1  one-cycle pulse; target_curr valid and updated
- target_curr  out  12  unsigned target motor current, held between results

## Operation
- Reset values: state IDLE; busy=0, done=0, target_curr=12'h000; all operand and product registers 0.
- Operands are preprocessed combinationally and registered on capture:
  - Incline saturation: incline_sat = incline clamped to signed 10-bit [-512, 511].
  - Incline factor: incline_factor = sign-extended incline_sat + 256 (11-bit signed). incline_lim (9-bit) = 0 if negative, 511 if >511, else the value.
  - Cadence: cadence_factor (6-bit) = 0 if cadence_vec[4:1]==0 (not pedaling), else cadence_vec+32.
  - Torque: torque_pos (12-bit) = avg_torque−TORQUE_MIN, floored at 0.
- FSM states, in order:
  - IDLE: start=1 captures operands and setting, then goes to MUL_CI.
  - MUL_CI: prod1 = cadence_factor×incline_lim (15-bit), then goes to MUL_T.
  - MUL_T: prod2 = torque_pos×prod1 (27-bit), then goes to SCALE.
  - SCALE: prod3 = prod2×setting (29-bit). Computed by shift-add (0→0, 1→x, 2→x<<1, 3→x+(x<<1)), not by the multiplier. Then goes to SAT.
  - SAT: target_curr = 12'hFFF if any of prod3[28:26] is set, else prod3[25:14]. Asserts done. Returns to IDLE.
- The shared multiplier is 15×15 unsigned → 30 bits. Operand muxes are selected by state; zero-extend narrower operands.
- start outside IDLE is ignored; it is not queued.
- Inputs changing after capture do not affect the in-flight result.
- rst at any cycle, including mid-sequence, forces the reset values on the next edge. No partial result is published.

## Timing
- Edge 0: start=1 in IDLE.
- Edge 4: target_curr and done registered; latency 4 cycles from the capture edge.
- busy is 1 after edges 0–3 and is 0 after edge 4, so it falls in the same cycle done is high.
- A start presented while done=1 is accepted. Maximum throughput is one result per 4 cycles.
- target_curr changes only on the edge that asserts done (or on reset).

## Structure
- Package drive_pkg holds:
  - TORQUE_MIN default
  - the state enum (IDLE, MUL_CI, MUL_T, SCALE, SAT)
  - width constants (15, 27, 29)
- Sub-module drive_mult15: combinational 15×15 unsigned multiplier, instantiated once.
- Incline saturation and limit logic stays inline.

## Test plan
- Nominal: avg_torque=12'h580, cadence_vec=5'h10, incline=0, setting=2, start pulse → done at edge 4, target_curr=12'h300, busy high for exactly 4 cycles.
- Saturation: avg_torque=12'hFFF, cadence_vec=5'h1F, incline=13'h00FF, setting=3 → target_curr=12'hFFF. incline=13'h0FFF clamps to incline_lim=511.
- Zero paths, each producing target_curr=0:
  - cadence_vec=5'h01
  - incline=−300
  - avg_torque=12'h37F
  - setting=0
- Start while busy: second start at edges 1–3 with different operands → ignored; one done; result from the first operands. Start on the done cycle → accepted, next done 4 cycles later.
- Reset mid-op: rst at edge 2 → busy=0, done never pulses, target_curr=0; a fresh start completes normally.
- Input hold: change all inputs every cycle after capture → result matches the captured values.
